mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit splitting accesses between data memory and a waited IO bus
// One request in flight at a time; results are registered single-cycle pulses with no backpressure.
module mem_access_unit #(
   parameter int unsigned DM_AW      = 12,
   parameter logic [15:0] IO_BASE    = 16'h3000,
   parameter int unsigned IO_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_we,
   input  logic             in_re,
   input  logic [1:0]       in_size,
   input  logic             in_unsigned,
   input  logic [31:0]      in_addr,
   input  logic [31:0]      in_wdata,
   input  logic [4:0]       in_rw,
   input  logic             in_regwrite,
   input  logic             flush,
   output logic             dm_en,
   output logic [3:0]       dm_we,
   output logic [DM_AW-1:0] dm_addr,
   output logic [31:0]      dm_wdata,
   input  logic [31:0]      dm_rdata,
   output logic             io_req,
   output logic             io_we,
   output logic [29:0]      io_addr,
   output logic [31:0]      io_wdata,
   output logic [3:0]       io_be,
   input  logic [31:0]      io_rdata,
   input  logic             io_ack,
   output logic             out_valid,
   output logic [4:0]       out_rw,
   output logic             out_regwrite,
   output logic [31:0]      out_wdata,
   output logic             out_err
);

   typedef enum logic [1:0] {S_IDLE, S_DM_RD, S_IO_WAIT} state_t;

   localparam logic [7:0] LP_TO_LAST = 8'(IO_TIMEOUT - 1);

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_wait;
   logic        r_flushed;
   logic [4:0]  r_rw;
   logic        r_regwrite;
   logic [1:0]  r_off;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic        r_is_load;
   logic        r_io_we;
   logic [29:0] r_io_addr;
   logic [31:0] r_io_wdata;
   logic [3:0]  r_io_be;

   logic        r_out_valid;
   logic [4:0]  r_out_rw;
   logic        r_out_regwrite;
   logic [31:0] r_out_wdata;
   logic        r_out_err;

   logic        w_accept, w_mem, w_store, w_is_io, w_misal;
   logic [3:0]  w_be;
   logic [31:0] w_wdata_sh;
   logic        w_res_valid, w_res_err, w_res_regwrite;
   logic [31:0] w_res_wdata;
   logic [4:0]  w_res_rw;

   function automatic logic [31:0] f_extract(input logic [31:0] rdata, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
      logic [31:0] s;
      s = rdata >> {off, 3'b000};
      case (size)
         2'b00:   f_extract = uns ? {24'b0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
         2'b01:   f_extract = uns ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
         default: f_extract = s;
      endcase
   endfunction

   assign in_ready   = (r_state == S_IDLE);
   assign w_accept   = in_valid && in_ready && !flush;
   assign w_mem      = in_we || in_re;
   assign w_store    = in_we;
   assign w_is_io    = (in_addr[15:0] >= IO_BASE);
   assign w_wdata_sh = in_wdata << {in_addr[1:0], 3'b000};

   // size 2'b11 is treated as a word access for both enables and alignment
   always_comb begin
      w_be    = 4'b1111;
      w_misal = 1'b0;
      case (in_size)
         2'b00: w_be = 4'b0001 << in_addr[1:0];
         2'b01: begin
            w_be    = in_addr[1] ? 4'b1100 : 4'b0011;
            w_misal = in_addr[0];
         end
         default: w_misal = (in_addr[1:0] != 2'b00);
      endcase
   end

   assign dm_en    = w_accept && w_mem && !w_misal && !w_is_io;
   assign dm_we    = (dm_en && w_store) ? w_be : 4'b0000;
   assign dm_addr  = in_addr[DM_AW+1:2];
   assign dm_wdata = w_wdata_sh;

   assign io_req   = (r_state == S_IO_WAIT);
   assign io_we    = r_io_we;
   assign io_addr  = r_io_addr;
   assign io_wdata = r_io_wdata;
   assign io_be    = r_io_be;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_res_valid    = 1'b0;
      w_res_err      = 1'b0;
      w_res_regwrite = 1'b0;
      w_res_wdata    = 32'b0;
      w_res_rw       = r_rw;
      case (r_state)
         S_IDLE: begin
            w_res_rw = in_rw;
            if (w_accept) begin
               if (!w_mem) begin
                  w_res_valid    = 1'b1;
                  w_res_wdata    = in_addr;
                  w_res_regwrite = in_regwrite;
               end else if (w_misal) begin
                  w_res_valid = 1'b1;
                  w_res_err   = 1'b1;
               end else if (w_is_io) begin
                  w_state_nxt = S_IO_WAIT;
               end else if (w_store) begin
                  w_res_valid = 1'b1;
               end else begin
                  w_state_nxt = S_DM_RD;
               end
            end
         end
         S_DM_RD: begin
            w_state_nxt    = S_IDLE;
            w_res_valid    = !flush;
            w_res_wdata    = f_extract(dm_rdata, r_off, r_size, r_unsigned);
            w_res_regwrite = r_regwrite;
         end
         S_IO_WAIT: begin
            // ack wins over a timeout landing in the same cycle
            if (io_ack) begin
               w_state_nxt    = S_IDLE;
               w_res_valid    = !(r_flushed || flush);
               w_res_wdata    = r_is_load ? f_extract(io_rdata, r_off, r_size, r_unsigned) : 32'b0;
               w_res_regwrite = r_is_load && r_regwrite;
            end else if (r_wait == LP_TO_LAST) begin
               w_state_nxt = S_IDLE;
               w_res_valid = !(r_flushed || flush);
               w_res_err   = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wait     <= 8'd0;
         r_flushed  <= 1'b0;
         r_rw       <= 5'd0;
         r_regwrite <= 1'b0;
         r_off      <= 2'd0;
         r_size     <= 2'd0;
         r_unsigned <= 1'b0;
         r_is_load  <= 1'b0;
         r_io_we    <= 1'b0;
         r_io_addr  <= 30'd0;
         r_io_wdata <= 32'd0;
         r_io_be    <= 4'd0;
      end else begin
         if (r_state == S_IO_WAIT && w_state_nxt == S_IO_WAIT) r_wait <= r_wait + 8'd1;
         else                                                   r_wait <= 8'd0;
         if (w_accept) begin
            r_flushed  <= 1'b0;
            r_rw       <= in_rw;
            r_regwrite <= in_regwrite;
            r_off      <= in_addr[1:0];
            r_size     <= in_size;
            r_unsigned <= in_unsigned;
            r_is_load  <= in_re && !in_we;
            r_io_we    <= in_we;
            r_io_addr  <= in_addr[31:2];
            r_io_wdata <= w_wdata_sh;
            r_io_be    <= w_be;
         end else if (r_state == S_IO_WAIT && flush) begin
            r_flushed <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid    <= 1'b0;
         r_out_rw       <= 5'd0;
         r_out_regwrite <= 1'b0;
         r_out_wdata    <= 32'd0;
         r_out_err      <= 1'b0;
      end else begin
         r_out_valid <= w_res_valid;
         if (w_res_valid) begin
            r_out_rw       <= w_res_rw;
            r_out_regwrite <= w_res_regwrite;
            r_out_wdata    <= w_res_wdata;
            r_out_err      <= w_res_err;
         end
      end
   end

   assign out_valid    = r_out_valid;
   assign out_rw       = r_out_rw;
   assign out_regwrite = r_out_regwrite;
   assign out_wdata    = r_out_wdata;
   assign out_err      = r_out_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

   logic        clk, rst;
   logic        in_valid, in_ready, in_we, in_re, in_unsigned, in_regwrite, flush;
   logic [1:0]  in_size;
   logic [31:0] in_addr, in_wdata;
   logic [4:0]  in_rw;
   logic        dm_en;
   logic [3:0]  dm_we;
   logic [11:0] dm_addr;
   logic [31:0] dm_wdata, dm_rdata;
   logic        io_req, io_we, io_ack;
   logic [29:0] io_addr;
   logic [31:0] io_wdata, io_rdata;
   logic [3:0]  io_be;
   logic        out_valid, out_regwrite, out_err;
   logic [4:0]  out_rw;
   logic [31:0] out_wdata;

   int n_tests = 0;
   int n_fail  = 0;

   mem_access_unit #(.DM_AW(12), .IO_BASE(16'h3000), .IO_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_re(in_re),
      .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_rw(in_rw), .in_regwrite(in_regwrite), .flush(flush),
      .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_be(io_be),
      .io_rdata(io_rdata), .io_ack(io_ack),
      .out_valid(out_valid), .out_rw(out_rw), .out_regwrite(out_regwrite),
      .out_wdata(out_wdata), .out_err(out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic we, input logic re, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] rw, input logic rwr);
      in_valid    = 1'b1;
      in_we       = we;
      in_re       = re;
      in_size     = size;
      in_unsigned = uns;
      in_addr     = addr;
      in_wdata    = wdata;
      in_rw       = rw;
      in_regwrite = rwr;
   endtask

   task automatic drop_req();
      in_valid = 1'b0;
      in_we    = 1'b0;
      in_re    = 1'b0;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; io_ack = 1'b0;
      io_rdata = 32'h0; dm_rdata = 32'h0;
      in_size = 2'b00; in_unsigned = 1'b0; in_addr = 32'h0; in_wdata = 32'h0;
      in_rw = 5'd0; in_regwrite = 1'b0;
      drop_req();
      #12;
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_io_req", 32'(io_req), 0);
      check("rst_out_err", 32'(out_err), 0);
      check("rst_out_wdata", out_wdata, 0);
      check("rst_out_rw", 32'(out_rw), 0);
      tick(); tick();
      rst = 1'b1;
      tick();

      // byte store at offset 2
      drive_req(1, 0, 2'b00, 0, 32'h0000_0102, 32'h0000_00AB, 5'd3, 1);
      #1;
      check("sb_dm_en", 32'(dm_en), 1);
      check("sb_dm_we", 32'(dm_we), 32'h4);
      check("sb_dm_wdata", dm_wdata, 32'h00AB_0000);
      check("sb_dm_addr", 32'(dm_addr), 32'h40);
      tick(); drop_req();
      check("sb_out_valid", 32'(out_valid), 1);
      check("sb_out_regwrite", 32'(out_regwrite), 0);
      check("sb_out_rw", 32'(out_rw), 3);
      check("sb_in_ready", 32'(in_ready), 1);
      tick();
      check("sb_pulse_once", 32'(out_valid), 0);

      // half store at offset 2
      drive_req(1, 0, 2'b01, 0, 32'h0000_0012, 32'h0000_1234, 5'd1, 0);
      #1;
      check("sh_dm_we", 32'(dm_we), 32'hC);
      check("sh_dm_wdata", dm_wdata, 32'h1234_0000);
      tick(); drop_req(); tick();

      // half loads, signed then unsigned
      dm_rdata = 32'h8001_1234;
      drive_req(0, 1, 2'b01, 0, 32'h0000_0002, 0, 5'd7, 1);
      #1;
      check("lh_dm_en", 32'(dm_en), 1);
      check("lh_dm_we", 32'(dm_we), 0);
      tick(); drop_req();
      check("lh_busy", 32'(in_ready), 0);
      check("lh_t1_valid", 32'(out_valid), 0);
      tick();
      check("lh_valid", 32'(out_valid), 1);
      check("lh_signed", out_wdata, 32'hFFFF_8001);
      check("lh_rw", 32'(out_rw), 7);
      check("lh_regwrite", 32'(out_regwrite), 1);
      drive_req(0, 1, 2'b01, 1, 32'h0000_0002, 0, 5'd7, 1);
      tick(); drop_req(); tick();
      check("lhu_unsigned", out_wdata, 32'h0000_8001);

      // signed byte load from the top byte lane
      drive_req(0, 1, 2'b00, 0, 32'h0000_0003, 0, 5'd8, 1);
      tick(); drop_req(); tick();
      check("lb_signed", out_wdata, 32'hFFFF_FF80);

      // IO load acked on the third wait cycle
      drive_req(0, 1, 2'b10, 0, 32'h0000_3004, 0, 5'd9, 1);
      #1;
      check("iol_no_dm", 32'(dm_en), 0);
      tick(); drop_req();
      check("iol_req_t1", 32'(io_req), 1);
      check("iol_addr", 32'(io_addr), 32'hC01);
      check("iol_be", 32'(io_be), 32'hF);
      check("iol_we", 32'(io_we), 0);
      tick();
      check("iol_req_t2", 32'(io_req), 1);
      tick();
      check("iol_req_t3", 32'(io_req), 1);
      io_ack = 1'b1; io_rdata = 32'h1234_5678;
      tick();
      io_ack = 1'b0;
      check("iol_req_drop", 32'(io_req), 0);
      check("iol_valid", 32'(out_valid), 1);
      check("iol_data", out_wdata, 32'h1234_5678);
      check("iol_err", 32'(out_err), 0);

      // IO store never acked -> timeout after 4 wait cycles
      drive_req(1, 0, 2'b10, 0, 32'h0000_3008, 32'h0000_0055, 5'd4, 1);
      tick(); drop_req();
      check("ios_we", 32'(io_we), 1);
      check("ios_wdata", io_wdata, 32'h55);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ios_req_c%0d", i), 32'(io_req), 1);
         check($sformatf("ios_novalid_c%0d", i), 32'(out_valid), 0);
         tick();
      end
      check("ios_req_drop", 32'(io_req), 0);
      check("ios_valid", 32'(out_valid), 1);
      check("ios_err", 32'(out_err), 1);
      check("ios_regwrite", 32'(out_regwrite), 0);
      check("ios_in_ready", 32'(in_ready), 1);
      tick();

      // misaligned word load
      drive_req(0, 1, 2'b10, 0, 32'h0000_0006, 0, 5'd5, 1);
      #1;
      check("mis_no_dm", 32'(dm_en), 0);
      tick(); drop_req();
      check("mis_valid", 32'(out_valid), 1);
      check("mis_err", 32'(out_err), 1);
      check("mis_regwrite", 32'(out_regwrite), 0);
      check("mis_no_io", 32'(io_req), 0);
      tick();

      // flush in the accept cycle drops the request
      drive_req(1, 0, 2'b10, 0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd6, 0);
      flush = 1'b1;
      #1;
      check("fa_dm_we", 32'(dm_we), 0);
      tick(); flush = 1'b0; drop_req();
      check("fa_no_valid", 32'(out_valid), 0);
      check("fa_no_io", 32'(io_req), 0);
      check("fa_idle", 32'(in_ready), 1);

      // flush during DM_RD
      drive_req(0, 1, 2'b10, 0, 32'h0000_0020, 0, 5'd6, 1);
      tick(); drop_req(); flush = 1'b1;
      tick(); flush = 1'b0;
      check("fd_no_valid", 32'(out_valid), 0);
      check("fd_idle", 32'(in_ready), 1);

      // flush during IO_WAIT, then ack; next request right after io_req drops
      drive_req(0, 1, 2'b10, 0, 32'h0000_3000, 0, 5'd2, 1);
      tick(); drop_req(); flush = 1'b1;
      check("fi_req", 32'(io_req), 1);
      tick(); flush = 1'b0;
      check("fi_req_held", 32'(io_req), 1);
      io_ack = 1'b1; io_rdata = 32'hCAFE_0000;
      tick(); io_ack = 1'b0;
      check("fi_req_drop", 32'(io_req), 0);
      check("fi_no_valid", 32'(out_valid), 0);
      check("fi_ready", 32'(in_ready), 1);
      drive_req(0, 0, 2'b10, 0, 32'h1234_5678, 0, 5'd11, 1);
      tick(); drop_req();
      check("np_valid", 32'(out_valid), 1);
      check("np_wdata", out_wdata, 32'h1234_5678);
      check("np_rw", 32'(out_rw), 11);
      check("np_regwrite", 32'(out_regwrite), 1);
      check("np_err", 32'(out_err), 0);

      // reset while waiting on IO
      drive_req(0, 1, 2'b10, 0, 32'h0000_3010, 0, 5'd12, 1);
      tick(); drop_req();
      check("rio_req", 32'(io_req), 1);
      #2 rst = 1'b0;
      #1;
      check("rio_req_drop", 32'(io_req), 0);
      check("rio_ready", 32'(in_ready), 1);
      tick(); rst = 1'b1;
      tick();
      check("rio_no_valid", 32'(out_valid), 0);
      check("rio_no_req", 32'(io_req), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
